// File: rtl/sar_pkg.sv
// sar_pkg: shared constants, FSM state encoding and comparator flag types
// for the successive-approximation search block.
package sar_pkg;

    localparam int SAR_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } sar_state_e;

    typedef struct packed {
        logic alb;
        logic aeb;
        logic agb;
    } cmp_flags_t;

    // Odd parity excludes zero/two set; the AND term removes the all-set case.
    function automatic logic flags_onehot(input cmp_flags_t f);
        return (f.alb ^ f.aeb ^ f.agb) & ~(f.alb & f.aeb & f.agb);
    endfunction

endpackage

// File: rtl/sar_search_if.sv
// sar_search_if: start/result handshake and comparator request/verdict bundle.
// The search engine connects through the slave modport.
interface sar_search_if
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
);
    logic             start;
    logic             busy;
    logic [WIDTH-1:0] trial;
    logic             trial_valid;
    logic             cmp_valid;
    logic             cmp_alb;
    logic             cmp_aeb;
    logic             cmp_agb;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;
    logic             done;

    modport master (
        output start, cmp_valid, cmp_alb, cmp_aeb, cmp_agb,
        input  busy, trial, trial_valid, result, found, err, done
    );

    modport slave (
        input  start, cmp_valid, cmp_alb, cmp_aeb, cmp_agb,
        output busy, trial, trial_valid, result, found, err, done
    );
endinterface

// File: rtl/sar_search_cmp_flag_check.sv
// cmp_flag_check: validates that a comparator verdict is one-hot and decodes
// it; lt/eq/gt are only asserted for a well-formed verdict.
module cmp_flag_check
    import sar_pkg::*;
(
    input  cmp_flags_t flags,
    output logic       lt,
    output logic       eq,
    output logic       gt,
    output logic       bad
);
    always_comb begin
        bad = ~flags_onehot(flags);
        lt  = flags.alb & ~bad;
        eq  = flags.aeb & ~bad;
        gt  = flags.agb & ~bad;
    end
endmodule

// File: rtl/sar_search.sv
// sar_search: MSB-first successive-approximation search against an external
// ALB/AEB/AGB comparator. Define SAR_EARLY_EXIT_EN to stop on the first exact match.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic        clk,
    input  logic        rst_n,
    sar_search_if.slave bus
);
    localparam int            KW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_MSB    = KW'(WIDTH - 1);
    localparam logic [1:0]    ST_IDLE   = S_IDLE;
    localparam logic [1:0]    ST_ISSUE  = S_ISSUE;
    localparam logic [1:0]    ST_VERIFY = S_VERIFY;
    localparam logic [1:0]    ST_DONE   = S_DONE;

    logic [1:0]       state, state_d;
    logic [WIDTH-1:0] cand, cand_d;
    logic [KW-1:0]    k, k_d;
    logic             fnd, fnd_d;
    logic             err_d;
    logic [WIDTH-1:0] result_q;
    logic             found_q;
    logic             err_q;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial_c;
    logic             tv;
    logic             early_exit;
    logic             v_lt, v_eq, v_gt, v_bad;
    cmp_flags_t       flags;

    assign flags = {bus.cmp_alb, bus.cmp_aeb, bus.cmp_agb};

    cmp_flag_check u_chk (
        .flags (flags),
        .lt    (v_lt),
        .eq    (v_eq),
        .gt    (v_gt),
        .bad   (v_bad)
    );

`ifdef SAR_EARLY_EXIT_EN
    assign early_exit = v_eq;
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        bit_mask = WIDTH'(1) << k;
        tv       = (state == ST_ISSUE) || (state == ST_VERIFY);
        case (state)
            ST_ISSUE:  trial_c = cand | bit_mask;
            ST_VERIFY: trial_c = cand;
            default:   trial_c = '0;
        endcase
    end

    always_comb begin
        state_d = state;
        cand_d  = cand;
        k_d     = k;
        fnd_d   = fnd;
        err_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ISSUE;
                    cand_d  = '0;
                    k_d     = K_MSB;
                    fnd_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (bus.cmp_valid) begin
                    if (v_bad) begin
                        err_d   = 1'b1;
                        fnd_d   = 1'b0;
                        cand_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        if (v_lt || v_eq) cand_d = cand | bit_mask;
                        if (v_eq) fnd_d = 1'b1;
                        // A match already seen makes the final VERIFY redundant.
                        if (k == '0 || early_exit)
                            state_d = fnd_d ? ST_DONE : ST_VERIFY;
                        else
                            k_d = k - KW'(1);
                    end
                end
            end
            ST_VERIFY: begin
                if (bus.cmp_valid) begin
                    state_d = ST_DONE;
                    if (v_bad) begin
                        err_d  = 1'b1;
                        fnd_d  = 1'b0;
                        cand_d = '0;
                    end else begin
                        fnd_d = v_eq;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers load on entry to DONE so they are visible with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cand     <= '0;
            k        <= '0;
            fnd      <= 1'b0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_d;
            cand  <= cand_d;
            k     <= k_d;
            fnd   <= fnd_d;
            if (state_d == ST_DONE) begin
                result_q <= cand_d;
                found_q  <= fnd_d;
                err_q    <= err_d;
            end
        end
    end

    assign bus.busy        = tv;
    assign bus.trial_valid = tv;
    assign bus.trial       = trial_c;
    assign bus.result      = result_q;
    assign bus.found       = found_q;
    assign bus.err         = err_q;
    assign bus.done        = (state == ST_DONE);

endmodule
